// File: rtl/wma_channel_scheduler.sv
// -----------------------------------------------------------------------------
// wma_channel_scheduler
//
// Shares one combinational WMA datapath between NUM_CH temperature-sensor
// channels. Each channel has a one-entry capture buffer with a pending bit.
// Pending samples are granted in round-robin order. Each grant takes three
// cycles: IDLE (grant and operand load), ISSUE (operands settle) and
// CAPTURE (the datapath result is stored as the channel's new WMA history).
// The result is published together with an out-of-band alarm.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   samp_valid   per-channel one-cycle strobe: a new sample is present
//   samp_data    channel i sample at bits [8i+7:8i], unsigned
//   thr_sel      global threshold select, latched when a grant is issued
//   clr_overrun  clears all sticky overrun flags (a same-cycle set wins)
//   dp_x         datapath current-temperature operand (registered)
//   dp_wma0      datapath previous-WMA operand (registered)
//   dp_thr_sel   datapath threshold select (registered)
//   dp_wma1      datapath WMA1 result
//   dp_t1        datapath lower threshold
//   dp_t2        datapath upper threshold
//   res_valid    one-cycle strobe: the res_* fields are valid
//   res_ch       channel index of the result
//   res_wma      new WMA for res_ch
//   res_alarm    sample was outside [T1,T2]
//   overrun      sticky per channel: a pending sample was overwritten
//   busy         scheduler is in ISSUE or CAPTURE
// -----------------------------------------------------------------------------
module wma_channel_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     samp_valid,
  input  logic [8*NUM_CH-1:0]   samp_data,
  input  logic [1:0]            thr_sel,
  input  logic                  clr_overrun,
  output logic [7:0]            dp_x,
  output logic [7:0]            dp_wma0,
  output logic [1:0]            dp_thr_sel,
  input  logic [7:0]            dp_wma1,
  input  logic [7:0]            dp_t1,
  input  logic [7:0]            dp_t2,
  output logic                  res_valid,
  output logic [CH_W-1:0]       res_ch,
  output logic [7:0]            res_wma,
  output logic                  res_alarm,
  output logic [NUM_CH-1:0]     overrun,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t              state_reg;
  logic [7:0]          buf_reg [NUM_CH];
  logic [7:0]          wma_reg [NUM_CH];
  logic [NUM_CH-1:0]   pend_reg;
  logic [NUM_CH-1:0]   hist_valid_reg;
  logic [NUM_CH-1:0]   overrun_reg;
  logic [CH_W-1:0]     rr_ptr_reg;
  logic [CH_W-1:0]     g_reg;

  logic [7:0]          dp_x_reg;
  logic [7:0]          dp_wma0_reg;
  logic [1:0]          dp_thr_sel_reg;
  logic                res_valid_reg;
  logic [CH_W-1:0]     res_ch_reg;
  logic [7:0]          res_wma_reg;
  logic                res_alarm_reg;

  // Round-robin search results
  logic [CH_W:0]       cand;
  logic [CH_W-1:0]     gnt_idx;
  logic                gnt_found;
  logic                grant_fire;
  logic [CH_W-1:0]     g_plus_one;

  logic [NUM_CH-1:0]   consume;
  logic [NUM_CH-1:0]   pend_next;
  logic [NUM_CH-1:0]   overrun_next;

  // First pending channel starting at rr_ptr, wrapping modulo NUM_CH.
  // The extra bit on cand covers rr_ptr+k before the wrap is applied.
  always_comb begin
    cand      = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, rr_ptr_reg} + (CH_W+1)'(k);
      if (cand >= (CH_W+1)'(NUM_CH)) begin
        cand = cand - (CH_W+1)'(NUM_CH);
      end
      if (!gnt_found && pend_reg[cand[CH_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[CH_W-1:0];
      end
    end
  end

  assign grant_fire = (state_reg == IDLE) && gnt_found;
  assign g_plus_one = (g_reg == CH_W'(NUM_CH - 1)) ? '0 : g_reg + CH_W'(1);

  // Per-channel pending/overrun next state. A grant in the same cycle as a
  // new arrival consumes the old entry, so the new sample is not an overrun.
  // An overrun set takes priority over clr_overrun.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign consume[gi]      = grant_fire && (gnt_idx == CH_W'(gi));
      assign pend_next[gi]    = samp_valid[gi] | (pend_reg[gi] & ~consume[gi]);
      assign overrun_next[gi] = (samp_valid[gi] & pend_reg[gi] & ~consume[gi]) |
                                (overrun_reg[gi] & ~clr_overrun);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pend_reg       <= '0;
      hist_valid_reg <= '0;
      overrun_reg    <= '0;
      rr_ptr_reg     <= '0;
      g_reg          <= '0;
      dp_x_reg       <= '0;
      dp_wma0_reg    <= '0;
      dp_thr_sel_reg <= '0;
      res_valid_reg  <= 1'b0;
      res_ch_reg     <= '0;
      res_wma_reg    <= '0;
      res_alarm_reg  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        buf_reg[i] <= '0;
        wma_reg[i] <= '0;
      end
    end else begin
      pend_reg      <= pend_next;
      overrun_reg   <= overrun_next;
      res_valid_reg <= 1'b0;

      // Newest sample always wins the buffer; the grant below reads the
      // pre-edge value, so a same-cycle arrival does not disturb it.
      for (int i = 0; i < NUM_CH; i++) begin
        if (samp_valid[i]) begin
          buf_reg[i] <= samp_data[8*i +: 8];
        end
      end

      case (state_reg)
        IDLE: begin
          if (grant_fire) begin
            dp_x_reg       <= buf_reg[gnt_idx];
            // First sample on a channel seeds the average with itself
            dp_wma0_reg    <= hist_valid_reg[gnt_idx] ? wma_reg[gnt_idx]
                                                      : buf_reg[gnt_idx];
            dp_thr_sel_reg <= thr_sel;
            g_reg          <= gnt_idx;
            state_reg      <= ISSUE;
          end
        end

        ISSUE: begin
          state_reg <= CAPTURE;
        end

        CAPTURE: begin
          wma_reg[g_reg]        <= dp_wma1;
          hist_valid_reg[g_reg] <= 1'b1;
          res_valid_reg         <= 1'b1;
          res_ch_reg            <= g_reg;
          res_wma_reg           <= dp_wma1;
          res_alarm_reg         <= (dp_x_reg < dp_t1) || (dp_x_reg > dp_t2);
          rr_ptr_reg            <= g_plus_one;
          state_reg             <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign dp_x       = dp_x_reg;
  assign dp_wma0    = dp_wma0_reg;
  assign dp_thr_sel = dp_thr_sel_reg;
  assign res_valid  = res_valid_reg;
  assign res_ch     = res_ch_reg;
  assign res_wma    = res_wma_reg;
  assign res_alarm  = res_alarm_reg;
  assign overrun    = overrun_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: doc/wma_channel_scheduler.md
Name: wma_channel_scheduler

Overview:
Time-multiplexes one shared combinational WMA_Calculator datapath across NUM_CH temperature-sensor channels. It holds the per-channel WMA history and grants pending samples in round-robin order. It drives the datapath operands from registers, captures WMA1/T1/T2 one cycle later, writes the new WMA back and publishes a result with an out-of-band alarm. It sits between the sensor front-ends and downstream logging/alarm logic.

Parameters:
NUM_CH, 4, number of sensor channels (2..8)
CH_W, 2, channel index width, equal to clog2(NUM_CH)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
samp_valid  input  NUM_CH  one-cycle strobe per channel: a new sample is present
samp_data  input  8*NUM_CH  channel i sample at bits [8i+7:8i], unsigned temperature
thr_sel  input  2  global threshold select (P=32/64/128), latched at issue
clr_overrun  input  1  clears all overrun flags
dp_x  output  8  datapath current-temperature operand (registered)
dp_wma0  output  8  datapath previous-WMA operand (registered)
dp_thr_sel  output  2  datapath threshold_select (registered)
dp_wma1  input  8  datapath WMA1 result
dp_t1  input  8  datapath lower threshold
dp_t2  input  8  datapath upper threshold
res_valid  output  1  one-cycle strobe: result fields valid
res_ch  output  CH_W  channel index of the result
res_wma  output  8  new WMA for res_ch
res_alarm  output  1  sample outside [T1,T2]
overrun  output  NUM_CH  sticky: a pending sample was overwritten
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; all outputs 0; pending, hist_valid and overrun all cleared; per-channel buffers and WMA registers 0; rr_ptr=0.
- Capture buffer: one 8-bit entry plus a pend bit per channel. When samp_valid[i]=1, the buffer is loaded and pend[i] is set. If pend[i] was already set and that entry is not consumed in the same cycle, set overrun[i]; the newest sample wins.
- Simultaneous arrival and grant on the same channel: the grant consumes the old entry and the new sample is stored with pend=1. No overrun is flagged.
- clr_overrun clears all overrun bits. If an overrun event occurs in the same cycle, the set wins.
- FSM states are IDLE, ISSUE and CAPTURE.
- IDLE: if any pend bit is set, grant the first set channel searching rr_ptr, rr_ptr+1, ... modulo NUM_CH. Then clear pend[g] and register dp_x=buffer[g]. Register dp_wma0=wma[g] if hist_valid[g]=1, else dp_wma0=buffer[g] (seed case). Register dp_thr_sel=thr_sel, store g, and go to ISSUE.
- ISSUE: hold the operands stable for one cycle so the datapath can settle, then go to CAPTURE.
- CAPTURE: sample dp_wma1/dp_t1/dp_t2. Write wma[g]=dp_wma1 and set hist_valid[g]=1. Drive res_valid=1 for this cycle with res_ch=g and res_wma=dp_wma1. Set res_alarm=1 iff dp_x<dp_t1 or dp_x>dp_t2 (unsigned compare). Set rr_ptr=g+1 modulo NUM_CH and return to IDLE.
- Throughput is one result per 3 cycles. Latency from a grant in IDLE to res_valid is 2 cycles.
- res_ch, res_wma and res_alarm hold their values until the next CAPTURE. dp_* hold their values until the next grant.
- thr_sel changes are ignored mid-operation because the value is latched in IDLE.
- Reset mid-operation aborts: no res_valid is produced and all history is lost.
- busy=1 in ISSUE and CAPTURE.

Test Plan:
Stub datapath for all scenarios: dp_wma1=(dp_x+dp_wma0)>>1, dp_t1=dp_wma1-4, dp_t2=dp_wma1+4.
- Seed: samp_valid[0] with data 100 -> 3 cycles later res_ch=0, res_wma=100, res_alarm=0, and dp_wma0 observed as 100.
- History and alarm: after the seed, ch0 sample 120 -> dp_wma0=100, res_wma=110, T2=114, res_alarm=1. A following sample 112 -> res_wma=111, res_alarm=0.
- Round robin: all 4 channels strobed in the same cycle from reset -> results in order ch0, ch1, ch2, ch3 every 3 cycles. Re-strobing all 4 after ch1 was last granted -> order ch2, ch3, ch0, ch1.
- Overrun: ch2 strobed with 50 then 60 while busy on ch0 -> overrun[2]=1 and ch2 result uses x=60. clr_overrun -> overrun=0.
- Same-cycle arrival and grant: ch1 strobed with 70 in the cycle ch1 is granted with 40 -> result uses 40, pend[1] stays set, a second ch1 result uses 70, and no overrun.
- Async reset asserted in ISSUE -> all outputs 0 immediately, no res_valid. The next sample on that channel is treated as a seed.
